// File: rtl/dct_coeff_reorder_buffer.sv
// dct_coeff_reorder_buffer: ping-pong buffer that collects 8 coefficient pairs
// in any order and streams the 16 coefficients out in natural index order.
module dct_coeff_reorder_buffer #(
    parameter int COEF_W = 18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_en,
    input  logic signed [COEF_W-1:0] IN_A,
    input  logic signed [COEF_W-1:0] IN_B,
    input  logic [3:0]               IDX_A,
    input  logic [3:0]               IDX_B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_data,
    output logic [3:0]               out_idx,
    output logic                     out_last,
    output logic                     overflow,
    input  logic                     clr_err
);
    logic signed [COEF_W-1:0] r_mem [2][16];
    logic [1:0] r_full;
    logic       r_wr_bank, r_rd_bank, r_drop, r_overflow;
    logic [2:0] r_cnt;
    logic [3:0] r_rd_idx;
    logic       w_xfer, w_rd_done, w_start, w_drop_start, w_drop, w_we, w_blk_end;

    assign out_valid    = r_full[r_rd_bank];
    assign out_data     = out_valid ? r_mem[r_rd_bank][r_rd_idx] : '0;
    assign out_idx      = out_valid ? r_rd_idx : '0;
    assign out_last     = out_valid & (r_rd_idx == 4'd15);
    assign overflow     = r_overflow;
    assign w_xfer       = out_valid & out_ready;
    assign w_rd_done    = w_xfer & (r_rd_idx == 4'd15);
    assign w_start      = in_en & (r_cnt == 3'd0);
    // a bank releasing its last coefficient this cycle counts as free
    assign w_drop_start = r_full[r_wr_bank] & ~(w_rd_done & (r_rd_bank == r_wr_bank));
    assign w_drop       = (r_cnt == 3'd0) ? w_drop_start : r_drop;
    assign w_we         = reset_n & in_en & ~w_drop;
    assign w_blk_end    = w_we & (r_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_bank][IDX_A] <= IN_A;
            r_mem[r_wr_bank][IDX_B] <= IN_B;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
            r_rd_idx   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (in_en) begin
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd0) r_drop <= w_drop_start;
            end
            if (w_xfer) r_rd_idx <= r_rd_idx + 4'd1;
            if (w_rd_done) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_blk_end) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_start & w_drop_start) r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dct_coeff_reorder_buffer.sv
// tb_dct_coeff_reorder_buffer: randomized and directed stimulus against a
// block-level scoreboard model of the reorder buffer.
module tb_dct_coeff_reorder_buffer;
    localparam int W = 18;

    typedef struct {
        logic [3:0]          idx;
        logic signed [W-1:0] data;
    } item_t;

    logic clk = 0, reset_n = 0, in_en = 0, out_ready = 0, clr_err = 0;
    logic signed [W-1:0] IN_A = '0, IN_B = '0, out_data;
    logic [3:0] IDX_A = '0, IDX_B = '0, out_idx;
    logic out_valid, out_last, overflow;

    dct_coeff_reorder_buffer #(.COEF_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_en(in_en), .IN_A(IN_A), .IN_B(IN_B),
        .IDX_A(IDX_A), .IDX_B(IDX_B), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .overflow(overflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int rdy_mode = 0;
    bit rdy_val = 0;
    int ord[16], vals[16];
    int ser[16] = '{0, 8, 4, 12, 2, 6, 10, 14, 1, 3, 5, 7, 9, 11, 13, 15};

    item_t exp_q[$];
    logic signed [W-1:0] cur[2][16];
    int  pcnt = 0, m_wb = 0;
    bit  m_drop = 0, m_ovf = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = rdy_mode == 0 ? rdy_val : rdy_mode == 1 ? !out_ready : 1'($urandom_range(0, 1));
    end

    // reference model plus monitor; inputs are stable at the falling edge
    always @(negedge clk) begin
        int sz;
        bit push, set_ovf;
        item_t it;
        if (!reset_n) begin
            exp_q.delete();
            pcnt = 0; m_wb = 0; m_drop = 0; m_ovf = 0;
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_ovf", int'(overflow), 0);
        end else begin
            sz = exp_q.size();
            push = 0; set_ovf = 0;
            if (in_en) begin
                if (pcnt == 0) begin
                    // both banks hold undrained blocks unless the older one finishes now
                    m_drop = (sz > 16) && !(out_ready && (sz % 16 == 1));
                    set_ovf = m_drop;
                end
                if (!m_drop) begin
                    cur[m_wb][IDX_A] = IN_A;
                    cur[m_wb][IDX_B] = IN_B;
                    push = (pcnt == 7);
                end
                pcnt = (pcnt + 1) % 8;
            end
            chk("valid", int'(out_valid), int'(sz > 0));
            if (out_valid && sz > 0) begin
                chk("data", int'(out_data), int'(exp_q[0].data));
                chk("idx", int'(out_idx), int'(exp_q[0].idx));
                chk("last", int'(out_last), int'(exp_q[0].idx == 4'd15));
                if (out_ready) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("idle_out", int'(out_data) | int'(out_idx) | int'(out_last), 0);
            end
            chk("overflow", int'(overflow), int'(m_ovf));
            if (push) begin
                for (int i = 0; i < 16; i++) begin
                    it.idx = 4'(i);
                    it.data = cur[m_wb][i];
                    exp_q.push_back(it);
                end
                m_wb ^= 1;
            end
            if (set_ovf) m_ovf = 1;
            else if (clr_err) m_ovf = 0;
        end
    end

    task automatic pair(int ia, int ib, int a, int b);
        @(posedge clk); #1;
        in_en = 1; clr_err = 0;
        IDX_A = 4'(ia); IDX_B = 4'(ib);
        IN_A = W'(a); IN_B = W'(b);
    endtask

    task automatic idle(int n, bit rnd_clr = 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_en = 0;
            clr_err = rnd_clr ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    task automatic send_block(int npairs, int gapmax);
        for (int p = 0; p < npairs; p++) begin
            pair(ord[2*p], ord[2*p+1], vals[ord[2*p]], vals[ord[2*p+1]]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", int'(t >= 1000), 0);
    endtask

    task automatic shuffle();
        for (int i = 0; i < 16; i++) ord[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        idle(3);
        @(posedge clk); #1 reset_n = 1;
        // serializer order, streaming with ready held high
        rdy_val = 1;
        ord = ser;
        for (int i = 0; i < 16; i++) vals[i] = 100 + i;
        send_block(8, 0); idle(1);
        wait_drain();
        // ready toggling during the drain
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) vals[i] = 200 + i;
        send_block(8, 0); idle(1);
        wait_drain();
        rdy_mode = 0;
        // three blocks with ready low: third is dropped
        rdy_val = 0; idle(2);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) vals[i] = 300 + 100 * b + i;
            send_block(8, 0); idle(1);
        end
        idle(2);
        chk("ovf_after_drop", int'(overflow), 1);
        rdy_val = 1;
        wait_drain();
        @(posedge clk); #1 clr_err = 1;
        idle(2);
        chk("ovf_cleared", int'(overflow), 0);
        // new block start coincides with the final read of its target bank
        rdy_val = 0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) vals[i] = 600 + 100 * b + i;
            send_block(8, 0); idle(1);
        end
        idle(2);
        @(posedge clk); #1 rdy_val = 1;
        idle(14);
        for (int i = 0; i < 16; i++) vals[i] = 800 + i;
        send_block(8, 0); idle(1);
        wait_drain();
        chk("ovf_coincide", int'(overflow), 0);
        // reset in the middle of a block
        for (int i = 0; i < 16; i++) vals[i] = 900 + i;
        send_block(4, 0);
        @(posedge clk); #1 reset_n = 0; in_en = 1;
        @(posedge clk); #1 reset_n = 1; in_en = 0;
        idle(1);
        chk("rst_valid_after", int'(out_valid), 0);
        shuffle();
        for (int i = 0; i < 16; i++) vals[i] = -i;
        send_block(8, 1); idle(1);
        wait_drain();
        // equal indices in one pair: B wins
        ord = '{5, 5, 0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        for (int i = 0; i < 16; i++) vals[i] = 1000 + i;
        pair(5, 5, 7, 9);
        for (int p = 1; p < 8; p++) pair(ord[2*p], ord[2*p+1], vals[ord[2*p]], vals[ord[2*p+1]]);
        idle(1);
        wait_drain();
        // random traffic with random backpressure and clears
        rdy_mode = 2;
        for (int b = 0; b < 12; b++) begin
            shuffle();
            for (int i = 0; i < 16; i++) vals[i] = int'($urandom_range(0, 262143)) - 131072;
            send_block(8, 2);
            idle($urandom_range(0, 6), 1);
        end
        idle(1);
        wait_drain();
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
